// File: rtl/booth_mult_seq.sv
// Sequential radix-2 Booth multiplier, signed or unsigned per transaction, one multiply in flight.
// Latency: out_valid rises WIDTH+1 cycles after the accepting edge; initiation interval WIDTH+3.
// Backpressure: in_ready low while busy or holding a result; result held until out_valid&out_ready.
module booth_mult_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy
);
    localparam int N = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t           state;
    logic [N-1:0]     acc;
    logic [N-1:0]     q_reg;
    logic [N-1:0]     m_reg;
    logic             q_m1;
    logic [CNT_W-1:0] cnt;

    logic [N-1:0]     a_ext;
    logic [N-1:0]     b_ext;
    logic [N-1:0]     sum;
    logic [N-1:0]     acc_nxt;
    logic [N-1:0]     q_nxt;
    logic             last_step;

    // One extra sign bit lets unsigned operands and the most-negative signed value share one datapath.
    always_comb begin
        a_ext = is_signed ? {a_in[WIDTH-1], a_in} : {1'b0, a_in};
        b_ext = is_signed ? {b_in[WIDTH-1], b_in} : {1'b0, b_in};

        sum = acc;
        unique case ({q_reg[0], q_m1})
            2'b01:   sum = acc + m_reg;
            2'b10:   sum = acc - m_reg;
            default: sum = acc;
        endcase

        acc_nxt = {sum[N-1], sum[N-1:1]};
        q_nxt   = {sum[0], q_reg[N-1:1]};
    end

    assign last_step = (cnt == CNT_W'(N - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            result    <= '0;
            cnt       <= '0;
            acc       <= '0;
            q_reg     <= '0;
            q_m1      <= 1'b0;
            m_reg     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        m_reg    <= a_ext;
                        q_reg    <= b_ext;
                        acc      <= '0;
                        q_m1     <= 1'b0;
                        cnt      <= '0;
                        state    <= BUSY;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                BUSY: begin
                    acc   <= acc_nxt;
                    q_reg <= q_nxt;
                    q_m1  <= q_reg[0];
                    cnt   <= cnt + CNT_W'(1);
                    if (last_step) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        // Low 2*WIDTH bits of the post-shift {A,Q}.
                        result    <= {acc_nxt[N-3:0], q_nxt};
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Bench for booth_mult_seq: WIDTH=16 and WIDTH=8 instances, scoreboard-queue checking.
module tb_booth_mult_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in_valid, in_ready, is_signed, out_valid, out_ready, busy;
    logic [15:0] a_in, b_in;
    logic [31:0] result;

    logic        in_valid8, in_ready8, is_signed8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8;
    logic [15:0] result8;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [15:0] exp8_q[$];

    booth_mult_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .busy(busy)
    );

    booth_mult_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a_in(a8), .b_in(b8), .is_signed(is_signed8), .out_valid(out_valid8),
        .out_ready(out_ready8), .result(result8), .busy(busy8)
    );

    function automatic logic [15:0] ref8(logic [7:0] a, logic [7:0] b, logic s);
        int x, y;
        if (s) begin
            x = int'($signed(a));
            y = int'($signed(b));
        end else begin
            x = int'(a);
            y = int'(b);
        end
        return 16'(x * y);
    endfunction

    // Drives one operand pair, perturbs inputs after acceptance, waits for the product.
    task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input logic [31:0] e, output logic [31:0] got, output int lat);
        int w;
        a_in = a; b_in = b; is_signed = s; in_valid = 1'b1; out_ready = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin @(negedge clk); w++; end
        exp_q.push_back(e);
        @(negedge clk);
        in_valid = 1'b0; is_signed = ~s; a_in = ~a; b_in = ~b;
        lat = 0;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        got = result;
        if (!out_valid) lat = -1;
        @(negedge clk);
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic [15:0] e, output logic [15:0] got, output int lat);
        int w;
        a8 = a; b8 = b; is_signed8 = s; in_valid8 = 1'b1; out_ready8 = 1'b1;
        w = 0;
        while (!in_ready8 && w < 100) begin @(negedge clk); w++; end
        exp8_q.push_back(e);
        @(negedge clk);
        in_valid8 = 1'b0; is_signed8 = ~s; a8 = ~a; b8 = ~b;
        lat = 0;
        while (!out_valid8 && lat < 100) begin @(negedge clk); lat++; end
        got = result8;
        if (!out_valid8) lat = -1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_valid = 0; a_in = 0; b_in = 0; is_signed = 0; out_ready = 0;
        in_valid8 = 0; a8 = 0; b8 = 0; is_signed8 = 0; out_ready8 = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({in_ready, out_valid, busy} !== 3'b100)
            $display("FAIL reset_flags got=%b want=100", {in_ready, out_valid, busy});
        else n_pass++;
        n_checks++;
        if (result !== 32'h0) $display("FAIL reset_result got=%h want=0", result);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned();
        logic [31:0] got, e;
        int lat;
        run16(16'd10, 16'd13, 1'b0, 32'h0000_0082, got, lat);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) $display("FAIL t1_result got=%h want=%h", got, e); else n_pass++;
        n_checks++;
        if (lat !== 17) $display("FAIL t1_latency got=%0d want=17", lat); else n_pass++;
    endtask

    task automatic test_signed();
        logic [15:0] av[3] = '{16'hFFF9, 16'h8000, 16'h7FFF};
        logic [15:0] bv[3] = '{16'h0005, 16'h8000, 16'h8000};
        logic [31:0] ev[3] = '{32'hFFFF_FFDD, 32'h4000_0000, 32'hC000_8000};
        logic [31:0] got, e;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run16(av[i], bv[i], 1'b1, ev[i], got, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL t2_signed[%0d] got=%h want=%h", i, got, e); else n_pass++;
        end
    endtask

    task automatic test_extremes();
        logic [15:0] av[3] = '{16'hFFFF, 16'hFFFF, 16'h0000};
        logic [15:0] bv[3] = '{16'hFFFF, 16'hFFFF, 16'hBEEF};
        logic        sv[3] = '{1'b0, 1'b1, 1'b1};
        logic [31:0] ev[3] = '{32'hFFFE_0001, 32'h0000_0001, 32'h0000_0000};
        logic [31:0] got, e;
        int lat;
        for (int i = 0; i < 3; i++) begin
            run16(av[i], bv[i], sv[i], ev[i], got, lat);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL t3_extreme[%0d] got=%h want=%h", i, got, e); else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] snap, e;
        int w, lat;
        logic bad;
        out_ready = 1'b0;
        a_in = 16'd100; b_in = 16'd200; is_signed = 1'b0; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin @(negedge clk); w++; end
        exp_q.push_back(32'd20000);
        @(negedge clk);
        // Second request held through BUSY and DONE; must wait for the handshake.
        a_in = 16'd3; b_in = 16'd7;
        w = 0;
        while (!out_valid && w < 100) begin @(negedge clk); w++; end
        snap = result;
        e = exp_q.pop_front();
        n_checks++;
        if (snap !== e) $display("FAIL t4_first got=%h want=%h", snap, e); else n_pass++;
        bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (result !== snap || in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad !== 1'b0) $display("FAIL t4_hold unstable=%b want=0", bad); else n_pass++;
        out_ready = 1'b1;
        exp_q.push_back(32'd21);
        @(negedge clk);
        n_checks++;
        if ({out_valid, in_ready, busy} !== 3'b010)
            $display("FAIL t4_after_hs got=%b want=010", {out_valid, in_ready, busy});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({busy, in_ready} !== 2'b10) $display("FAIL t4_accept got=%b want=10", {busy, in_ready});
        else n_pass++;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        e = exp_q.pop_front();
        n_checks++;
        if (result !== e || lat !== 17) $display("FAIL t4_second got=%h lat=%0d want=%h lat=17", result, lat, e);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [31:0] e;
        int w, lat;
        out_ready = 1'b1;
        a_in = 16'd1000; b_in = 16'd3; is_signed = 1'b0; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 100) begin @(negedge clk); w++; end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, out_valid, busy} !== 3'b100)
            $display("FAIL t5_async_flags got=%b want=100", {in_ready, out_valid, busy});
        else n_pass++;
        n_checks++;
        if (result !== 32'h0) $display("FAIL t5_async_result got=%h want=0", result); else n_pass++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        a_in = 16'd320; b_in = 16'd140; in_valid = 1'b1;
        exp_q.push_back(32'd44800);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL t5_first_edge busy=%b want=1", busy); else n_pass++;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin @(negedge clk); lat++; end
        e = exp_q.pop_front();
        n_checks++;
        if (result !== e || lat !== 17) $display("FAIL t5_next got=%h lat=%0d want=%h lat=17", result, lat, e);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [15:0] av[4] = '{16'd1234, 16'hFFF0, 16'h00FF, 16'h8000};
        logic [15:0] bv[4] = '{16'd567,  16'h0010, 16'h0101, 16'h0001};
        logic        sv[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ev[4] = '{32'd699678, 32'hFFFF_FF00, 32'h0000_FFFF, 32'hFFFF_8000};
        int rise[$];
        int cyc, idx, done, double_hi;
        logic prev_ov;
        logic [31:0] e;
        cyc = 0; idx = 0; done = 0; double_hi = 0; prev_ov = 1'b0;
        out_ready = 1'b1; in_valid = 1'b0;
        while (done < 4 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                if (prev_ov) double_hi++;
                rise.push_back(cyc);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                n_checks++;
                if (result !== e) $display("FAIL b2b_result[%0d] got=%h want=%h", done, result, e);
                else n_pass++;
                done++;
            end
            prev_ov = out_valid;
            if (in_ready && idx < 4) begin
                a_in = av[idx]; b_in = bv[idx]; is_signed = sv[idx]; in_valid = 1'b1;
                exp_q.push_back(ev[idx]);
                idx++;
            end else begin
                in_valid = 1'b0;
            end
        end
        n_checks++;
        if (done !== 4 || double_hi !== 0)
            $display("FAIL b2b_count done=%0d long_done=%0d want=4/0", done, double_hi);
        else n_pass++;
        for (int i = 0; i + 1 < rise.size(); i++) begin
            n_checks++;
            if (rise[i+1] - rise[i] !== 19)
                $display("FAIL b2b_interval[%0d] got=%0d want=19", i, rise[i+1] - rise[i]);
            else n_pass++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_w8();
        logic [15:0] got, e;
        logic [7:0]  a, b;
        logic        s;
        int lat;
        run8(8'h80, 8'h7F, 1'b1, 16'hC080, got, lat);
        e = exp8_q.pop_front();
        n_checks++;
        if (got !== e) $display("FAIL t6_signed got=%h want=%h", got, e); else n_pass++;
        n_checks++;
        if (lat !== 9) $display("FAIL t6_latency got=%0d want=9", lat); else n_pass++;
        run8(8'h80, 8'h7F, 1'b0, 16'h3F80, got, lat);
        e = exp8_q.pop_front();
        n_checks++;
        if (got !== e) $display("FAIL t6_unsigned got=%h want=%h", got, e); else n_pass++;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            s = 1'($urandom_range(0, 1));
            run8(a, b, s, ref8(a, b, s), got, lat);
            e = exp8_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL t6_rand[%0d] a=%h b=%h s=%b got=%h want=%h", i, a, b, s, got, e);
            else n_pass++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_extremes();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        test_w8();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
